// File: rtl/sram_like_responder.sv
// rtl/sram_like_responder.sv - SRAM-like request/response responder with in-order outstanding queue
//
// Purpose : accepts requests into a QDEPTH-entry in-order queue, performs the RAM
//           access at accept time and issues one registered data_ok per request
//           once it has aged LATENCY cycles.
// Optional: define SRAM_LIKE_RAND_DELAY_EN to add a 0..3 cycle LFSR-chosen extra
//           delay to each request at the moment it becomes queue head.
// Ports   : clk, reset (async, active-high)
//           req, wr, size, addr, wstrb, wdata  - request side
//           addr_ok                            - accept indication (req & addr_ok)
//           data_ok, rdata                     - completion pulse and read data
module sram_like_responder #(
    parameter int MEM_AW  = 12,
    parameter int LATENCY = 2,
    parameter int QDEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int          QW       = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [QW:0] QFULL    = (QW + 1)'(QDEPTH);
    localparam logic [4:0]  BASE_THR = 5'(LATENCY - 1);
    localparam logic [3:0]  AGE_MAX  = 4'hF;

    // Word RAM, not reset.
    logic [31:0] mem [2**MEM_AW];

    // Outstanding queue.
    logic [QW-1:0] head;
    logic [QW-1:0] tail;
    logic [QW:0]   count;
    logic [QW:0]   count_nxt;
    logic          q_wr   [QDEPTH];
    logic [31:0]   q_data [QDEPTH];
    logic [3:0]    q_age  [QDEPTH];
    logic [QDEPTH-1:0] valid;

    logic              accept;
    logic              retire;
    logic [3:0]        thr;
    logic [MEM_AW-1:0] widx;
    logic              unused_bits;

    assign widx   = addr[MEM_AW+1:2];
    assign accept = req & addr_ok;

    // size is informational (wstrb decides lanes); addr bits outside the RAM index wrap.
    assign unused_bits = ^{size, addr[31:MEM_AW+2], addr[1:0]};

`ifdef SRAM_LIKE_RAND_DELAY_EN
    logic [15:0] lfsr;
    logic [1:0]  head_extra;
    logic [4:0]  thr_sum;

    // head_extra is refreshed whenever a new entry takes the head slot: either the
    // old head retires, or a request lands in an empty queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr       <= 16'hACE1;
            head_extra <= 2'd0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            if (retire || (accept && (count == '0))) begin
                head_extra <= lfsr[1:0];
            end
        end
    end

    // Ages saturate at 15, so the threshold is clamped there to guarantee retirement.
    assign thr_sum = BASE_THR + {3'b000, head_extra};
    assign thr     = (thr_sum > 5'(AGE_MAX)) ? AGE_MAX : thr_sum[3:0];
`else
    assign thr = BASE_THR[3:0];
`endif

    // Entry i is live when its distance from head is below count.
    always_comb begin
        valid = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            valid[i] = ({1'b0, QW'(i) - head} < count);
        end
    end

    assign retire    = (count != '0) && (q_age[head] >= thr);
    assign count_nxt = count + {{QW{1'b0}}, accept} - {{QW{1'b0}}, retire};

    // RAM write port: byte lanes per wstrb on accept.
    always_ff @(posedge clk) begin
        if (accept && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            addr_ok <= 1'b0;
            data_ok <= 1'b0;
            rdata   <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_wr[i]   <= 1'b0;
                q_data[i] <= '0;
                q_age[i]  <= '0;
            end
        end else begin
            // addr_ok looks only at the post-edge occupancy, so a full queue keeps it
            // low even during the cycle its head retires.
            addr_ok <= (count_nxt < QFULL);
            count   <= count_nxt;
            data_ok <= retire;

            if (retire) begin
                rdata <= q_wr[head] ? 32'h0 : q_data[head];
                head  <= head + QW'(1);
            end

            for (int i = 0; i < QDEPTH; i++) begin
                if (valid[i] && (q_age[i] != AGE_MAX)) begin
                    q_age[i] <= q_age[i] + 4'd1;
                end
            end

            // The tail slot is never live when accept fires, so this overrides the
            // age update above only for a free slot. Reads sample RAM here, after
            // every earlier-accepted write has already landed.
            if (accept) begin
                q_wr[tail]   <= wr;
                q_data[tail] <= wr ? 32'h0 : mem[widx];
                q_age[tail]  <= '0;
                tail         <= tail + QW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sram_like_responder.sv
// tb/tb_sram_like_responder.sv - self-checking bench for sram_like_responder
module tb_sram_like_responder;

    localparam int MEM_AW = 12;
    localparam int LAT    = 8;
    localparam int QD     = 4;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        req   = 1'b0;
    logic        wr    = 1'b0;
    logic [1:0]  size  = 2'd2;
    logic [31:0] addr  = '0;
    logic [3:0]  wstrb = '0;
    logic [31:0] wdata = '0;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    sram_like_responder #(
        .MEM_AW (MEM_AW),
        .LATENCY(LAT),
        .QDEPTH (QD)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .wr     (wr),
        .size   (size),
        .addr   (addr),
        .wstrb  (wstrb),
        .wdata  (wdata),
        .addr_ok(addr_ok),
        .data_ok(data_ok),
        .rdata  (rdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: each request is given its completion edge when accepted:
    // no earlier than accept+LAT and strictly after the previous completion.
    typedef struct {
        logic        wr;
        logic [31:0] data;
        longint      done;
    } txn_t;

    typedef struct {
        longint      e;
        logic [31:0] d;
    } pulse_t;

    txn_t        q[$];
    pulse_t      log_q[$];
    logic [31:0] mem_m [int];
    longint      edge_n    = 0;
    longint      last_done = 0;
    logic        m_addr_ok = 1'b0;
    logic        m_data_ok = 1'b0;
    logic [31:0] m_rdata   = '0;
    logic        dut_acc   = 1'b0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, then compare.
    task automatic cycle(input logic r, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        int          widx;
        logic [31:0] cur;
        txn_t        t;
        req = r; wr = w; addr = a; wstrb = s; wdata = d;
        dut_acc = r && addr_ok;
        @(posedge clk);
        edge_n++;
        m_data_ok = 1'b0;
        if (q.size() > 0 && q[0].done == edge_n) begin
            m_data_ok = 1'b1;
            m_rdata   = q[0].wr ? 32'h0 : q[0].data;
            void'(q.pop_front());
        end
        if (r && m_addr_ok) begin
            widx = int'((a >> 2) & ((32'd1 << MEM_AW) - 1));
            cur  = mem_m.exists(widx) ? mem_m[widx] : 32'h0;
            t.wr = w;
            if (w) begin
                for (int b = 0; b < 4; b++) if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
                mem_m[widx] = cur;
                t.data = 32'h0;
            end else begin
                t.data = cur;
            end
            t.done = (edge_n + LAT > last_done + 1) ? edge_n + LAT : last_done + 1;
            last_done = t.done;
            q.push_back(t);
        end
        m_addr_ok = (q.size() < QD);
        #1;
        chk("addr_ok", {31'b0, addr_ok}, {31'b0, m_addr_ok});
        chk("data_ok", {31'b0, data_ok}, {31'b0, m_data_ok});
        chk("rdata",   rdata, m_rdata);
        if (data_ok) log_q.push_back('{edge_n, rdata});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (q.size() > 0 && g < 100) begin
            idle(1);
            g++;
        end
        chk("drain bound", 32'(q.size()), 32'd0);
    endtask

    // Hold a request until accepted, bounded.
    task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d);
        int g;
        g = 0;
        cycle(1'b1, w, a, s, d);
        while (!dut_acc && g < 40) begin
            cycle(1'b1, w, a, s, d);
            g++;
        end
        chk("accept bound", {31'b0, dut_acc}, 32'd1);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        req   = 1'b0;
        #1;
        chk("reset addr_ok", {31'b0, addr_ok}, 32'd0);
        chk("reset data_ok", {31'b0, data_ok}, 32'd0);
        chk("reset rdata",   rdata, 32'd0);
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        last_done = 0;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
        m_rdata   = '0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   reopen;
        logic r, pw, pend;
        logic [31:0] pa, pd;
        logic [3:0]  ps;

        vecs[0]  = '{1'b1, 32'h0000_0100, 4'hF, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0100, 4'h0, 32'h0,        32'hDEADBEEF};
        vecs[2]  = '{1'b1, 32'h0000_0200, 4'hF, 32'h11223344, 32'h0};
        vecs[3]  = '{1'b1, 32'h0000_0200, 4'h1, 32'h000000AA, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0200, 4'h0, 32'h0,        32'h112233AA};
        vecs[5]  = '{1'b1, 32'h0000_0300, 4'hF, 32'hCAFEF00D, 32'h0};
        vecs[6]  = '{1'b1, 32'h0000_0300, 4'hC, 32'h12340000, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_0300, 4'h0, 32'h0,        32'h1234F00D};
        vecs[8]  = '{1'b0, 32'h0000_4100, 4'h0, 32'h0,        32'hDEADBEEF};
        vecs[9]  = '{1'b0, 32'h0000_0102, 4'h0, 32'h0,        32'hDEADBEEF};
        vecs[10] = '{1'b1, 32'h0000_3FFC, 4'hF, 32'hA5A5A5A5, 32'h0};
        vecs[11] = '{1'b0, 32'hFFFF_FFFC, 4'h0, 32'h0,        32'hA5A5A5A5};

        #2;
        do_reset(3);
        idle(1);
        chk("addr_ok after release", {31'b0, addr_ok}, 32'd1);
        log_q.delete();
        idle(20);
        chk("idle no data_ok", 32'(log_q.size()), 32'd0);

        // Single transactions: latency and returned data.
        for (int v = 0; v < 12; v++) begin
            issue(vecs[v].wr, vecs[v].addr, vecs[v].strb, vecs[v].wdata);
            lat = 0;
            while (!data_ok && lat < 40) begin
                idle(1);
                lat++;
            end
            chk($sformatf("vec%0d latency", v), 32'(lat), 32'(LAT));
            chk($sformatf("vec%0d rdata", v), rdata, vecs[v].exp_rdata);
        end

        // Prefill a pool of words with back-to-back held writes.
        for (int i = 0; i < 8; i++) issue(1'b1, 32'h400 + 32'(4 * i), 4'hF, 32'h1000 + 32'(i));
        drain();

        // Queue full: six held reads.
        log_q.delete();
        reopen = -1;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, 32'h400 + 32'(4 * i), 4'h0, 32'h0);
            if (i >= 4 && reopen < 0 && addr_ok) reopen = int'(edge_n);
            while (!dut_acc && edge_n < 100000) begin
                cycle(1'b1, 1'b0, 32'h400 + 32'(4 * i), 4'h0, 32'h0);
                if (reopen < 0 && addr_ok) reopen = int'(edge_n);
                if (log_q.size() > 6) break;
            end
            if (i == 3) chk("full addr_ok low", {31'b0, addr_ok}, 32'd0);
        end
        drain();
        chk("full pulse count", 32'(log_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < log_q.size(); i++)
            chk($sformatf("full order %0d", i), log_q[i].d, 32'h1000 + 32'(i));
        if (log_q.size() > 0)
            chk("full reopen with first data_ok", 32'(reopen), 32'(log_q[0].e));

        // Write then read of the same word in consecutive cycles.
        log_q.delete();
        cycle(1'b1, 1'b1, 32'h500, 4'hF, 32'h77778888);
        chk("b2b write accepted", {31'b0, dut_acc}, 32'd1);
        cycle(1'b1, 1'b0, 32'h500, 4'h0, 32'h0);
        chk("b2b read accepted", {31'b0, dut_acc}, 32'd1);
        drain();
        chk("b2b pulse count", 32'(log_q.size()), 32'd2);
        if (log_q.size() == 2) begin
            chk("b2b spacing", 32'(log_q[1].e - log_q[0].e), 32'd1);
            chk("b2b write rdata", log_q[0].d, 32'h0);
            chk("b2b read rdata", log_q[1].d, 32'h77778888);
        end

        // Reset with three reads in flight.
        for (int i = 0; i < 3; i++) issue(1'b0, 32'h400 + 32'(4 * i), 4'h0, 32'h0);
        log_q.delete();
        do_reset(2);
        idle(20);
        chk("mid reset no data_ok", 32'(log_q.size()), 32'd0);
        chk("mid reset addr_ok", {31'b0, addr_ok}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 32'h410 + 32'(4 * i), 4'h0, 32'h0);
            chk($sformatf("post reset accept %0d", i), {31'b0, dut_acc}, 32'd1);
        end
        chk("post reset full", {31'b0, addr_ok}, 32'd0);
        drain();

        // Randomized traffic over the pool, including aliased addresses.
        pend = 1'b0; r = 1'b0; pw = 1'b0; pa = '0; pd = '0; ps = '0;
        for (int c = 0; c < 600; c++) begin
            if (!pend) begin
                r = ($urandom_range(0, 99) < 60);
                if (r) begin
                    pw = ($urandom_range(0, 2) == 0);
                    pa = 32'h400 + 4 * $urandom_range(0, 7) + ($urandom_range(0, 1) != 0 ? 32'h4000 : 32'h0);
                    ps = 4'($urandom);
                    pd = $urandom;
                end
            end
            cycle(r, pw, pa, ps, pd);
            pend = r && !dut_acc;
        end
        drain();
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
